// File: rtl/frame_pkg.sv
// rtl/frame_pkg.sv - shared constants and state encoding for the frame decoder
package frame_pkg;

   localparam logic [7:0] HEADER = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LEN     = 3'd1,
      ST_PAYLOAD = 3'd2,
      ST_CHECK   = 3'd3,
      ST_SEND    = 3'd4
   } state_t;

   localparam logic [1:0] ERR_NONE = 2'd0;
   localparam logic [1:0] ERR_LEN  = 2'd1;
   localparam logic [1:0] ERR_CHK  = 2'd2;
   localparam logic [1:0] ERR_TMO  = 2'd3;

endpackage

// File: rtl/frame_buffer.sv
// rtl/frame_buffer.sv - payload store, one synchronous write port, one combinational read port
module frame_buffer #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data
);

   logic [7:0] mem_q [0:DEPTH-1];

   // write one payload byte; contents are never cleared, a new frame overwrites them
   always_ff @(posedge clk) begin
      if (wr_en && (int'(wr_addr) < DEPTH)) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   // read port; addresses past the end (only formed after the last byte) read as zero
   always_comb begin
      rd_data = 8'd0;
      if (int'(rd_addr) < DEPTH) begin
         rd_data = mem_q[rd_addr];
      end
   end

endmodule

// File: rtl/frame_decoder.sv
// rtl/frame_decoder.sv - header/length/payload/checksum frame parser with handshaked byte output
module frame_decoder
   import frame_pkg::*;
#(
   parameter int MAX_LEN = 8,
   parameter int TIMEOUT = 4096
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_last,
   output logic       err,
   output logic [1:0] err_code
);

   localparam int IW = $clog2(MAX_LEN + 1);
   localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
   localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

   state_t          state_q, state_d;
   logic [7:0]      len_q, len_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [7:0]      chk_q, chk_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic [7:0]      out_data_q, out_data_d;
   logic            out_valid_q, out_valid_d;
   logic            out_last_q, out_last_d;
   logic            err_q, err_d;
   logic [1:0]      err_code_q, err_code_d;

   logic            wr_en;
   logic [AW-1:0]   wr_addr;
   logic [AW-1:0]   rd_addr;
   logic [7:0]      rd_data;

   frame_buffer #(.DEPTH(MAX_LEN), .AW(AW)) u_buffer (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (in_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   // next-state, datapath and registered-output decode for the parser FSM
   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      idx_d       = idx_q;
      chk_d       = chk_q;
      tmo_d       = tmo_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      err_d       = 1'b0;
      err_code_d  = ERR_NONE;
      wr_en       = 1'b0;
      wr_addr     = AW'(idx_q);
      // CHECK preloads byte 0; SEND prefetches the byte after the one on the output
      rd_addr     = (state_q == ST_CHECK) ? '0 : AW'(idx_q + 1'b1);

      case (state_q)
         ST_IDLE: begin
            tmo_d = '0;
            if (in_valid && in_data == HEADER) begin
               state_d = ST_LEN;
            end
         end
         ST_LEN, ST_PAYLOAD, ST_CHECK: begin
            if (in_valid) begin
               tmo_d = '0;
               case (state_q)
                  ST_LEN: begin
                     if (in_data == 8'd0 || in_data > MAX_LEN_B) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_LEN;
                        state_d    = ST_IDLE;
                     end else begin
                        len_d   = in_data;
                        chk_d   = in_data;
                        idx_d   = '0;
                        state_d = ST_PAYLOAD;
                     end
                  end
                  ST_PAYLOAD: begin
                     wr_en = 1'b1;
                     chk_d = chk_q ^ in_data;
                     idx_d = idx_q + 1'b1;
                     if (8'(idx_q) + 8'd1 == len_q) begin
                        state_d = ST_CHECK;
                     end
                  end
                  default: begin
                     if (in_data == chk_q) begin
                        out_valid_d = 1'b1;
                        out_data_d  = rd_data;
                        out_last_d  = (len_q == 8'd1);
                        idx_d       = '0;
                        state_d     = ST_SEND;
                     end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_CHK;
                        state_d    = ST_IDLE;
                     end
                  end
               endcase
            end else if (tmo_q == TMO_LAST) begin
               tmo_d      = '0;
               err_d      = 1'b1;
               err_code_d = ERR_TMO;
               state_d    = ST_IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         ST_SEND: begin
            // input bytes cannot be buffered while draining, so they are reported and dropped
            if (in_valid) begin
               err_d      = 1'b1;
               err_code_d = ERR_TMO;
            end
            if (out_valid_q && out_ready) begin
               if (out_last_q) begin
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  out_data_d  = 8'd0;
                  state_d     = ST_IDLE;
               end else begin
                  idx_d      = idx_q + 1'b1;
                  out_data_d = rd_data;
                  out_last_d = (8'(idx_q) + 8'd2 == len_q);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // state and output registers; reset abandons any frame in flight without an error
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         len_q       <= 8'd0;
         idx_q       <= '0;
         chk_q       <= 8'd0;
         tmo_q       <= '0;
         out_data_q  <= 8'd0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         err_q       <= 1'b0;
         err_code_q  <= ERR_NONE;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         idx_q       <= idx_d;
         chk_q       <= chk_d;
         tmo_q       <= tmo_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         err_q       <= err_d;
         err_code_q  <= err_code_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign err       = err_q;
   assign err_code  = err_code_q;

endmodule

// File: tb/tb_frame_decoder.sv
// tb/tb_frame_decoder.sv - directed-vector self-checking bench for frame_decoder
module tb_frame_decoder;

   localparam int MAX_LEN = 8;
   localparam int TIMEOUT = 32;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in_data;
   logic       in_valid;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       out_last;
   logic       err;
   logic [1:0] err_code;

   int n_vec = 0;
   int n_bad = 0;
   int cyc = 0;
   int stab_bad = 0;
   int code_bad = 0;

   logic [7:0] hs_data[$];
   logic       hs_last[$];
   int         hs_cyc[$];
   logic [1:0] err_log[$];
   logic [8:0] exp_q[$];

   logic       hold_prev = 1'b0;
   logic [7:0] data_prev;
   logic       last_prev;

   frame_decoder #(.MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .err       (err),
      .err_code  (err_code)
   );

   always #5 clk = ~clk;

   // observe outputs on the falling edge: handshakes, error pulses, hold stability
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (!rst) begin
         if (hold_prev && (out_valid !== 1'b1 || out_data !== data_prev || out_last !== last_prev))
            stab_bad = stab_bad + 1;
         if (out_valid && out_ready) begin
            hs_data.push_back(out_data);
            hs_last.push_back(out_last);
            hs_cyc.push_back(cyc);
         end
         if (err) err_log.push_back(err_code);
         if (!err && err_code != 2'd0) code_bad = code_bad + 1;
         hold_prev = out_valid && !out_ready;
         data_prev = out_data;
         last_prev = out_last;
      end else begin
         hold_prev = 1'b0;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec = n_vec + 1;
      if (got !== exp) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [7:0] b);
      in_data  = b;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic clear_logs();
      hs_data.delete();
      hs_last.delete();
      hs_cyc.delete();
      err_log.delete();
      exp_q.delete();
   endtask

   task automatic expect_byte(input logic [7:0] d, input logic l);
      exp_q.push_back({l, d});
   endtask

   task automatic check_frame(input string tag);
      check({tag, "_count"}, hs_data.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < hs_data.size(); i++) begin
         check({tag, "_data"}, hs_data[i], exp_q[i][7:0]);
         check({tag, "_last"}, hs_last[i], exp_q[i][8]);
      end
   endtask

   initial begin
      rst       = 1'b1;
      in_data   = 8'd0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick(3);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last", out_last, 0);
      check("rst_out_data", out_data, 0);
      check("rst_err", err, 0);
      check("rst_err_code", err_code, 0);
      rst = 1'b0;

      // three-byte frame, consecutive delivery
      clear_logs();
      send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h03);
      check("first_valid", out_valid, 1);
      check("first_data", out_data, 8'h11);
      tick(5);
      expect_byte(8'h11, 0); expect_byte(8'h22, 0); expect_byte(8'h33, 1);
      check_frame("f3");
      if (hs_cyc.size() == 3) begin
         check("f3_gap01", hs_cyc[1] - hs_cyc[0], 1);
         check("f3_gap12", hs_cyc[2] - hs_cyc[1], 1);
      end
      check("f3_errs", err_log.size(), 0);

      // checksum mismatch
      clear_logs();
      send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'h00);
      check("chk_err", err, 1);
      check("chk_code", err_code, 2);
      check("chk_no_out", out_valid, 0);
      tick();
      check("chk_err_pulse", err, 0);
      tick(3);
      check("chk_errs", err_log.size(), 1);
      check_frame("chk");

      // length zero and length over maximum, then a one-byte frame
      clear_logs();
      send(8'hA5); send(8'h00);
      check("len0_err", err, 1);
      check("len0_code", err_code, 1);
      send(8'hA5); send(8'h09);
      check("len9_err", err, 1);
      check("len9_code", err_code, 1);
      send(8'hA5); send(8'h01); send(8'h5A); send(8'h5B);
      tick(4);
      check("len_errs", err_log.size(), 2);
      expect_byte(8'h5A, 1);
      check_frame("len1");

      // maximum length frame, XOR of 08 and 01..08 is 00
      clear_logs();
      send(8'hA5); send(8'h08);
      for (int i = 1; i <= 8; i++) send(8'(i));
      send(8'h00);
      tick(10);
      for (int i = 1; i <= 8; i++) expect_byte(8'(i), (i == 8));
      check_frame("max");
      check("max_errs", err_log.size(), 0);

      // inter-byte timeout
      clear_logs();
      send(8'hA5); send(8'h02); send(8'h10);
      tick(TIMEOUT - 1);
      check("tmo_early", err, 0);
      tick();
      check("tmo_err", err, 1);
      check("tmo_code", err_code, 3);
      tick();
      send(8'hA5); send(8'h02); send(8'h01); send(8'h02); send(8'h01);
      tick(4);
      check("tmo_errs", err_log.size(), 1);
      expect_byte(8'h01, 0); expect_byte(8'h02, 1);
      check_frame("tmo_next");

      // backpressure with an injected byte during SEND
      clear_logs();
      out_ready = 1'b0;
      send(8'hA5); send(8'h02); send(8'hAA); send(8'hBB); send(8'h13);
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, 8'hAA);
      tick(3);
      send(8'h77);
      check("bp_inj_err", err, 1);
      check("bp_inj_code", err_code, 3);
      tick(5);
      check("bp_hold_data", out_data, 8'hAA);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_last", out_last, 0);
      out_ready = 1'b1;
      tick(4);
      expect_byte(8'hAA, 0); expect_byte(8'hBB, 1);
      check_frame("bp");
      check("bp_errs", err_log.size(), 1);
      if (err_log.size() == 1) check("bp_err_kind", err_log[0], 3);

      // back-to-back frames with no idle gap
      clear_logs();
      send(8'hA5); send(8'h01); send(8'h33); send(8'h32);
      tick();
      send(8'hA5); send(8'h01); send(8'h44); send(8'h45);
      tick(4);
      expect_byte(8'h33, 1); expect_byte(8'h44, 1);
      check_frame("b2b");
      check("b2b_errs", err_log.size(), 0);

      // reset while a frame is held in SEND
      clear_logs();
      out_ready = 1'b0;
      send(8'hA5); send(8'h01); send(8'h66); send(8'h67);
      check("rs_pre_valid", out_valid, 1);
      rst = 1'b1;
      #1;
      check("rs_valid", out_valid, 0);
      check("rs_data", out_data, 0);
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      tick(3);
      check_frame("rs_none");

      // reset mid-payload, then a fresh frame
      clear_logs();
      send(8'hA5); send(8'h04); send(8'h01); send(8'h02);
      rst = 1'b1;
      #1;
      check("rp_valid", out_valid, 0);
      check("rp_last", out_last, 0);
      check("rp_data", out_data, 0);
      check("rp_err", err, 0);
      check("rp_code", err_code, 0);
      tick(2);
      rst = 1'b0;
      send(8'hA5); send(8'h03); send(8'h07); send(8'h08); send(8'h09); send(8'h05);
      tick(5);
      expect_byte(8'h07, 0); expect_byte(8'h08, 0); expect_byte(8'h09, 1);
      check_frame("rp_next");
      check("rp_errs", err_log.size(), 0);

      check("hold_stable", stab_bad, 0);
      check("err_code_idle", code_bad, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
